// File: rtl/flash_sram_bus_controller_if.sv
// Host/memory bus bundle for flash_sram_bus_controller.
// The slave modport is the controller; master is the requesting host plus device model.
interface flash_sram_bus_controller_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 16
) ();
  logic              req;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              wp_lock;
  logic              busy;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_dout;
  logic [DATA_W-1:0] mem_din;
  logic              flash_ce_n;
  logic              sram_ce_n;
  logic              oe_n;
  logic              we_n;
  logic              wp_n;

  modport slave (
    input  req, wr, addr, wdata, wp_lock, mem_din,
    output busy, done, err, rdata, mem_addr, mem_dout,
           flash_ce_n, sram_ce_n, oe_n, we_n, wp_n
  );

  modport master (
    output req, wr, addr, wdata, wp_lock, mem_din,
    input  busy, done, err, rdata, mem_addr, mem_dout,
           flash_ce_n, sram_ce_n, oe_n, we_n, wp_n
  );
endinterface

// File: rtl/flash_sram_bus_controller.sv
// Single-request Flash/SRAM bus controller: address decode, write protect,
// fixed SETUP / ACCESS(W) / HOLD strobe sequence with fully registered outputs.
module flash_sram_bus_controller #(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DATA_W      = 16,
  parameter logic [ADDR_W-1:0] FLASH_BASE  = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] FLASH_LIMIT = 32'h0FFF_FFFF,
  parameter logic [ADDR_W-1:0] SRAM_BASE   = 32'h1000_0000,
  parameter logic [ADDR_W-1:0] SRAM_LIMIT  = 32'h44E1_1FFF,
  parameter int unsigned       FLASH_WAIT  = 4,
  parameter int unsigned       SRAM_WAIT   = 2
) (
  input logic                         clk,
  input logic                         RESET,
  flash_sram_bus_controller_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, ERROR} state_t;

  localparam logic [3:0] FLASH_CNT = 4'(FLASH_WAIT - 1);
  localparam logic [3:0] SRAM_CNT  = 4'(SRAM_WAIT - 1);

  state_t            state;
  logic [3:0]        wait_cnt;
  logic              wr_q;
  logic              sel_flash;
  logic              hit_flash;
  logic              hit_sram;
  logic [DATA_W-1:0] din_s;

  // Offset compare keeps the check valid for any base, including zero.
  function automatic logic in_range(input logic [ADDR_W-1:0] a,
                                    input logic [ADDR_W-1:0] base,
                                    input logic [ADDR_W-1:0] limit);
    return (a - base) <= (limit - base);
  endfunction

  always_comb begin
    hit_flash = in_range(bus.addr, FLASH_BASE, FLASH_LIMIT);
    hit_sram  = in_range(bus.addr, SRAM_BASE, SRAM_LIMIT);
    din_s     = bus.mem_din;
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      wr_q           <= 1'b0;
      sel_flash      <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.err        <= 1'b0;
      bus.rdata      <= '0;
      bus.mem_addr   <= '0;
      bus.mem_dout   <= '0;
      bus.flash_ce_n <= 1'b1;
      bus.sram_ce_n  <= 1'b1;
      bus.oe_n       <= 1'b1;
      bus.we_n       <= 1'b1;
      bus.wp_n       <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req) begin
            bus.busy     <= 1'b1;
            wr_q         <= bus.wr;
            bus.mem_addr <= bus.addr;
            if (bus.wr) begin
              bus.mem_dout <= bus.wdata;
            end
            // Flash is tested first so it wins wherever the ranges overlap.
            if (hit_flash && !(bus.wr && bus.wp_lock)) begin
              state          <= SETUP;
              sel_flash      <= 1'b1;
              bus.flash_ce_n <= 1'b0;
              bus.wp_n       <= bus.wr;
            end else if (!hit_flash && hit_sram) begin
              state         <= SETUP;
              sel_flash     <= 1'b0;
              bus.sram_ce_n <= 1'b0;
            end else begin
              state    <= ERROR;
              bus.done <= 1'b1;
              bus.err  <= 1'b1;
            end
          end
        end

        SETUP: begin
          state    <= ACCESS;
          wait_cnt <= sel_flash ? FLASH_CNT : SRAM_CNT;
          if (wr_q) begin
            bus.we_n <= 1'b0;
          end else begin
            bus.oe_n <= 1'b0;
          end
        end

        ACCESS: begin
          if (wait_cnt == 4'd0) begin
            state    <= HOLD;
            bus.oe_n <= 1'b1;
            bus.we_n <= 1'b1;
            bus.done <= 1'b1;
            if (!wr_q) begin
              bus.rdata <= din_s;
            end
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end

        HOLD: begin
          state          <= IDLE;
          bus.busy       <= 1'b0;
          bus.flash_ce_n <= 1'b1;
          bus.sram_ce_n  <= 1'b1;
          bus.wp_n       <= 1'b0;
        end

        ERROR: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/flash_sram_bus_controller.md
FLASH_SRAM_BUS_CONTROLLER -- requirements
Module: flash_sram_bus_controller

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and RESET.
REQ-002 Parameter ADDR_W, default 32, SHALL set the address width.
REQ-003 Parameter DATA_W, default 16, SHALL set the data width.
REQ-004 Parameters FLASH_BASE/FLASH_LIMIT, defaults 32'h0000_0000/32'h0FFF_FFFF, SHALL set the inclusive Flash range.
REQ-005 Parameters SRAM_BASE/SRAM_LIMIT, defaults 32'h1000_0000/32'h44E1_1FFF, SHALL set the inclusive SRAM range.
REQ-006 Parameters FLASH_WAIT/SRAM_WAIT, defaults 4/2, legal range 1..15, SHALL set the ACCESS-phase length in cycles.
REQ-007 Ports SHALL be (name, direction, width, meaning):
 clk  in  1  rising-edge clock
 RESET  in  1  synchronous active-high reset
 req  in  1  access request
 wr  in  1  1=write, 0=read; sampled with req
 addr  in  ADDR_W  access address; sampled with req
 wdata  in  DATA_W  write data; sampled with req
 wp_lock  in  1  1=Flash writes forbidden; sampled with req
 busy  out  1  transaction in progress; req ignored while high
 done  out  1  one-cycle completion pulse
 err  out  1  valid with done; 1=access rejected
 rdata  out  DATA_W  read data; valid from done, held until next read completes
 mem_addr  out  ADDR_W  registered device address
 mem_dout  out  DATA_W  registered device write data
 mem_din  in  DATA_W  device read data
 flash_ce_n / sram_ce_n  out  1  active-low chip enables
 oe_n / we_n  out  1  active-low output/write enables, shared
 wp_n  out  1  active-low Flash write protect

Function
REQ-008 States SHALL be IDLE, SETUP, ACCESS, HOLD and ERROR; all outputs SHALL be registered.
REQ-009 In IDLE with req=1, the block SHALL latch wr/addr/wdata/wp_lock, set busy=1, and decode the region.
REQ-010 If addr is in neither range, or is a Flash write with wp_lock=1, the next state SHALL be ERROR; otherwise SETUP.
REQ-011 If the ranges overlap, Flash SHALL take priority.
REQ-012 ERROR SHALL last 1 cycle with done=1 and err=1; no CE, OE or WE SHALL assert; the next state SHALL be IDLE.
REQ-013 SETUP SHALL last 1 cycle: the selected CE low, mem_addr driven, mem_dout driven on writes, oe_n=we_n=1.
REQ-014 ACCESS SHALL last W cycles (W=FLASH_WAIT or SRAM_WAIT per region), holding CE low, with oe_n=0 for a read or we_n=0 for a write.
REQ-015 On the final ACCESS cycle of a read, mem_din SHALL be captured into rdata.
REQ-016 HOLD SHALL last 1 cycle: CE low, oe_n=we_n=1, done=1, err=0; the next state SHALL be IDLE with busy=0.
REQ-017 Latency SHALL be fixed: done is high exactly W+2 cycles after the req-sampling edge, and 1 cycle after it for ERROR.
REQ-018 oe_n and we_n SHALL never be low together, and no more than one CE SHALL be low at any time.
REQ-019 wp_n SHALL be 0 except from SETUP through HOLD of an accepted Flash write, where it SHALL be 1.
REQ-020 A req held high SHALL be re-sampled in the first IDLE cycle after HOLD or ERROR, giving back-to-back transactions with one IDLE cycle between them.
REQ-021 The wait counter SHALL be 4 bits wide and load W-1 on entry to ACCESS; W=1 SHALL give exactly one ACCESS cycle.

Reset
REQ-022 RESET=1 at a rising edge SHALL force state=IDLE, busy=0, done=0, err=0, rdata=0, mem_addr=0, mem_dout=0, flash_ce_n=sram_ce_n=oe_n=we_n=1, wp_n=0.
REQ-023 RESET during any state SHALL abort the transaction on that edge with no done pulse, overriding a simultaneous req.

Verification
REQ-024 Flash read: req, wr=0, addr=32'h0000_1000, mem_din=16'hBEEF -> flash_ce_n low for 6 cycles, oe_n low for 4, done 6 cycles after req, rdata=16'hBEEF, err=0.
REQ-025 SRAM write: wr=1, addr=32'h2000_0000, wdata=16'h1234 -> sram_ce_n low for 4 cycles, we_n low for 2, mem_dout=16'h1234, flash_ce_n stays 1, wp_n stays 0.
REQ-026 Flash write: addr=32'h0000_0010 with wp_lock=1 -> ERROR, done=err=1 one cycle after req, no enables asserted; repeated with wp_lock=0 -> wp_n=1 for SETUP through HOLD, we_n low for 4 cycles.
REQ-027 Boundaries: addr=32'h44E1_1FFF -> SRAM access; addr=32'h44E1_2000 -> err=1; addr=32'h0FFF_FFFF -> Flash; addr=32'h1000_0000 -> SRAM.
REQ-028 req held high across 3 SRAM reads -> three done pulses, each 4 cycles after its accept edge and separated by one IDLE cycle; req pulsed while busy is ignored.
REQ-029 RESET asserted in the second ACCESS cycle of a Flash read -> all outputs at reset values on the next edge, no done pulse, and the next req completes normally.
